beam_monitor: RTL and testbench
===============================

BEAM_MONITOR -- requirements
Module: beam_monitor

Interface
REQ-001 SHALL have parameter NCH, 4, number of break-beam sensor channels (1..16).
REQ-002 SHALL have parameter CLK_DIV, 10000, clk cycles per sample tick (>=2).
REQ-003 SHALL have parameter DEB_TICKS, 3, consecutive differing ticks needed to change debounced state (1..15).
REQ-004 SHALL have parameter CNT_W, 8, per-channel event counter width.
REQ-005 SHALL have port clk  in  1  system clock (50 MHz); the block has one clock.
REQ-006 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port sense  in  NCH  raw sensor inputs, asynchronous; 0 = beam broken.
REQ-008 SHALL have port clr  in  1  synchronous clear of toggles, counts and pending events.
REQ-009 SHALL have port run  out  1  registered run indicator, 1 when not in reset.
REQ-010 SHALL have port brk  out  NCH  debounced state per channel; 1 = broken.
REQ-011 SHALL have port toggle  out  NCH  per-channel state inverting on each break event.
REQ-012 SHALL have port evt_valid  out  1  event offer valid.
REQ-013 SHALL have port evt_ch  out  max(1,clog2(NCH))  channel index of offered event.
REQ-014 SHALL have port evt_ready  in  1  consumer accepts offered event.
REQ-015 SHALL have port count  out  NCH*CNT_W  per-channel break counts, channel i at bits [i*CNT_W +: CNT_W] (BEAM_MONITOR_COUNT_EN only).

Function
REQ-016 SHALL pass each sense bit through a 2-flop synchronizer on clk.
REQ-017 SHALL run a prescaler 0..CLK_DIV-1 asserting a one-clk tick when value is CLK_DIV-1, then wrapping to 0.
REQ-018 SHALL, per channel on each tick, increment a stable counter if synchronized value (inverted) differs from brk, else zero it; on reaching DEB_TICKS, invert brk and zero the counter.
REQ-019 SHALL generate a one-clk break event when brk goes 0->1; 1->0 (beam restored) generates no event.
REQ-020 SHALL, on break event for channel i, invert toggle[i], increment count[i] saturating at all-ones, and set pending[i] one clk later.
REQ-021 SHALL coalesce an event on an already-pending channel (pending stays 1; toggle/count still update).
REQ-022 SHALL implement offer FSM IDLE/OFFER: IDLE with any pending -> latch lowest pending index into evt_ch, go OFFER; OFFER drives evt_valid=1.
REQ-023 SHALL hold evt_ch and evt_valid stable in OFFER until evt_valid&&evt_ready; then clear pending[evt_ch] and return to IDLE.
REQ-024 SHALL keep pending[i] set when its clear and a new event coincide in the same clk (set wins).
REQ-025 SHALL give latency: event at edge t -> pending at t+1 -> evt_valid at t+2; minimum two clks between accepted offers.
REQ-026 SHALL, on clr, zero toggle, count, pending, force IDLE and evt_valid=0 next clk; debounce and brk unaffected; clr wins over same-clk events.

Reset
REQ-027 SHALL asynchronously set on rst_n=0: run=0, brk=0, toggle=0, count=0, pending=0, evt_valid=0, evt_ch=0, FSM=IDLE, prescaler=0, stable counters=0, synchronizer flops=1.
REQ-028 SHALL set run=1 on first clk edge after rst_n deasserts; reset mid-offer drops the offer without handshake.

Configuration
REQ-029 SHALL compile per-channel counters and count port only when BEAM_MONITOR_COUNT_EN is defined; without it neither port nor counters exist and all other behaviour is unchanged.

Structure
REQ-030 SHALL place offer FSM state typedef and default parameter constants in package beam_monitor_pkg.
REQ-031 SHALL use one sub-module beam_channel (synchronizer, debounce, edge detect, toggle, counter), instantiated NCH times; prescaler, pending, FSM in top.

Verification (CLK_DIV=4, DEB_TICKS=3, NCH=4, CNT_W=4)
REQ-032 SHALL check: sense[1] low 20 clks -> brk[1]=1 after 3 ticks, toggle[1]=1, count[1]=1, evt_valid with evt_ch=1 2 clks after event.
REQ-033 SHALL check: sense[0] low glitch 8 clks (2 ticks) -> brk, toggle, count, evt_valid unchanged.
REQ-034 SHALL check: ch2 and ch0 break same clk, evt_ready=1 -> offers evt_ch=0 then evt_ch=2, each once.
REQ-035 SHALL check: evt_ready=0 while ch3 breaks 3 times -> single pending offer for ch3, count[3]=3, toggle[3]=1, evt_ch stable.
REQ-036 SHALL check: 17 breaks on ch1 -> count[1]=15 saturated; clr pulse -> count, toggle, evt_valid 0 next clk, brk unchanged.
REQ-037 SHALL check: rst_n low mid-offer -> all outputs at reset values immediately, run=1 one clk after release.

Source files
------------

// File: rtl/beam_monitor_pkg.sv
// Shared types and default parameter values for the beam monitor.
package beam_monitor_pkg;

  localparam int NCH_DEF       = 4;
  localparam int CLK_DIV_DEF   = 10000;
  localparam int DEB_TICKS_DEF = 3;
  localparam int CNT_W_DEF     = 8;

  // Width of the per-channel stable-tick counter; holds DEB_TICKS up to 15.
  localparam int STABLE_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } offer_state_t;

endpackage

// File: rtl/beam_channel.sv
// One break-beam channel: 2-flop synchronizer, tick-based debounce,
// break-edge event, toggle flag and (with BEAM_MONITOR_COUNT_EN) a
// saturating break counter.
module beam_channel
  import beam_monitor_pkg::*;
#(
  parameter int DEB_TICKS = DEB_TICKS_DEF
`ifdef BEAM_MONITOR_COUNT_EN
  , parameter int CNT_W = CNT_W_DEF
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sense,
  input  logic tick,
  input  logic clr,
  output logic brk,
  output logic toggle,
  output logic brk_evt
`ifdef BEAM_MONITOR_COUNT_EN
  , output logic [CNT_W-1:0] count
`endif
);

  logic                sync1;
  logic                sync2;
  logic [STABLE_W-1:0] stable_cnt;
  logic                differ;
  logic                flip;

  // sense is active-low (0 = broken), brk is active-high
  assign differ = (~sync2) != brk;
  assign flip   = tick && differ && (stable_cnt == STABLE_W'(DEB_TICKS - 1));

  // Synchronizer idles high (beam intact) so reset release cannot fake a break
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= sense;
      sync2 <= sync1;
    end
  end

  // Debounce: count consecutive differing ticks, flip brk on DEB_TICKS
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      brk        <= 1'b0;
      stable_cnt <= '0;
      brk_evt    <= 1'b0;
    end else begin
      brk_evt <= flip && !brk;
      if (tick) begin
        if (flip) begin
          brk        <= ~brk;
          stable_cnt <= '0;
        end else if (differ) begin
          stable_cnt <= stable_cnt + 1'b1;
        end else begin
          stable_cnt <= '0;
        end
      end
    end
  end

  // Toggle flips on each break event; clr takes priority over a same-clk event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      toggle <= 1'b0;
    end else if (clr) begin
      toggle <= 1'b0;
    end else if (brk_evt) begin
      toggle <= ~toggle;
    end
  end

`ifdef BEAM_MONITOR_COUNT_EN
  // Saturating break counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (brk_evt && !(&count)) begin
      count <= count + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/beam_monitor.sv
// Multi-channel break-beam monitor: shared sample-tick prescaler, NCH
// debounced channels, pending-event flags and an IDLE/OFFER handshake FSM
// that offers the lowest pending channel. Define BEAM_MONITOR_COUNT_EN to
// add per-channel saturating break counters and the count port.
module beam_monitor
  import beam_monitor_pkg::*;
#(
  parameter int NCH       = NCH_DEF,
  parameter int CLK_DIV   = CLK_DIV_DEF,
  parameter int DEB_TICKS = DEB_TICKS_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [NCH-1:0]                            sense,
  input  logic                                      clr,
  output logic                                      run,
  output logic [NCH-1:0]                            brk,
  output logic [NCH-1:0]                            toggle,
  output logic                                      evt_valid,
  output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0]  evt_ch,
  input  logic                                      evt_ready
`ifdef BEAM_MONITOR_COUNT_EN
  , output logic [NCH*CNT_W-1:0]                    count
`endif
);

  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int PW  = $clog2(CLK_DIV);

  logic [PW-1:0]  presc;
  logic           tick;
  logic [NCH-1:0] brk_evt;
  logic [NCH-1:0] pending;
  logic [NCH-1:0] accept_mask;
  logic [CHW-1:0] first_pend;
  offer_state_t   state_q;
  offer_state_t   state_d;
  logic           latch_ch;

  assign tick = (presc == PW'(CLK_DIV - 1));

  // Run indicator rises on the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run <= 1'b0;
    else        run <= 1'b1;
  end

  // Sample-tick prescaler wrapping at CLK_DIV-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + 1'b1;
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    beam_channel #(
      .DEB_TICKS(DEB_TICKS)
`ifdef BEAM_MONITOR_COUNT_EN
      , .CNT_W(CNT_W)
`endif
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .sense   (sense[i]),
      .tick    (tick),
      .clr     (clr),
      .brk     (brk[i]),
      .toggle  (toggle[i]),
      .brk_evt (brk_evt[i])
`ifdef BEAM_MONITOR_COUNT_EN
      , .count (count[i*CNT_W +: CNT_W])
`endif
    );
  end

  // Lowest-index pending channel
  always_comb begin
    first_pend = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (pending[i]) first_pend = CHW'(i);
    end
  end

  assign accept_mask = (state_q == OFFER && evt_ready) ? (NCH'(1) << evt_ch) : '0;

  // Pending flags: accepted channel clears, a coincident new event re-sets it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   pending <= '0;
    else if (clr) pending <= '0;
    else          pending <= (pending & ~accept_mask) | brk_evt;
  end

  // Offer FSM next-state
  always_comb begin
    state_d  = state_q;
    latch_ch = 1'b0;
    case (state_q)
      IDLE: begin
        if (|pending) begin
          state_d  = OFFER;
          latch_ch = 1'b1;
        end
      end
      OFFER: begin
        if (evt_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (clr) state_d = IDLE;
  end

  // Offer FSM state and latched channel index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      evt_ch  <= '0;
    end else begin
      state_q <= state_d;
      if (latch_ch && !clr) evt_ch <= first_pend;
    end
  end

  assign evt_valid = (state_q == OFFER);

endmodule

// File: tb/tb_beam_monitor.sv
// Self-checking bench for beam_monitor (NCH=4, CLK_DIV=4, DEB_TICKS=3,
// CNT_W=4). Count checks apply when BEAM_MONITOR_COUNT_EN is defined.
module tb_beam_monitor;

  localparam int NCH = 4;
  localparam int CLK_DIV = 4;
  localparam int DEB = 3;
  localparam int CNT_W = 4;

  logic                 clk;
  logic                 rst_n;
  logic [NCH-1:0]       sense;
  logic                 clr;
  logic                 run;
  logic [NCH-1:0]       brk;
  logic [NCH-1:0]       toggle;
  logic                 evt_valid;
  logic [1:0]           evt_ch;
  logic                 evt_ready;
`ifdef BEAM_MONITOR_COUNT_EN
  logic [NCH*CNT_W-1:0] count;
`endif

  beam_monitor #(.NCH(NCH), .CLK_DIV(CLK_DIV), .DEB_TICKS(DEB), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sense     (sense),
    .clr       (clr),
    .run       (run),
    .brk       (brk),
    .toggle    (toggle),
    .evt_valid (evt_valid),
    .evt_ch    (evt_ch),
    .evt_ready (evt_ready)
`ifdef BEAM_MONITOR_COUNT_EN
    , .count   (count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [NCH-1:0] p);
    for (int i = 0; i < NCH; i++) if (p[i]) return i;
    return 0;
  endfunction

  // ---------------- behavioural reference model ----------------
  // Sensor level seen by the debouncer lags the pin by two clocks; a tick
  // occurs every CLK_DIV clocks; DEB consecutive differing ticks flip brk.
  logic [NCH-1:0] m_hist[2];
  logic [NCH-1:0] m_brk, m_tog, m_pend, m_pend_before, m_evt, m_new;
  logic [3:0]     m_cnt[NCH];
  int             m_run[NCH];
  int             m_clk_in_period;
  logic           hs;
  logic [1:0]     hs_ch;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_hist[0] = '1; m_hist[1] = '1;
      m_brk = '0; m_tog = '0; m_pend = '0; m_pend_before = '0; m_evt = '0;
      m_clk_in_period = 0;
      for (int i = 0; i < NCH; i++) begin m_cnt[i] = '0; m_run[i] = 0; end
    end else begin
      m_pend_before = m_pend;
      if (clr) begin
        m_tog = '0; m_pend = '0;
        for (int i = 0; i < NCH; i++) m_cnt[i] = '0;
      end else begin
        if (hs) m_pend[hs_ch] = 1'b0;
        for (int i = 0; i < NCH; i++) if (m_evt[i]) begin
          m_tog[i] = !m_tog[i];
          m_pend[i] = 1'b1;
          if (m_cnt[i] != 4'hF) m_cnt[i] = m_cnt[i] + 4'd1;
        end
      end
      m_new = '0;
      if (m_clk_in_period == CLK_DIV - 1) begin
        for (int i = 0; i < NCH; i++) begin
          if ((!m_hist[1][i]) != m_brk[i]) begin
            m_run[i]++;
            if (m_run[i] == DEB) begin
              m_brk[i] = !m_brk[i];
              m_run[i] = 0;
              m_new[i] = m_brk[i];
            end
          end else m_run[i] = 0;
        end
      end
      m_clk_in_period = (m_clk_in_period + 1) % CLK_DIV;
      m_evt = m_new;
      m_hist[1] = m_hist[0];
      m_hist[0] = sense;
    end
  end

  // Continuous comparison against the model plus handshake properties
  logic       pv, phs, pclr;
  logic [1:0] pch;
  initial begin pv = 0; phs = 0; pclr = 0; pch = 0; hs = 0; hs_ch = 0; end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("brk", brk, m_brk);
      chk("toggle", toggle, m_tog);
`ifdef BEAM_MONITOR_COUNT_EN
      for (int i = 0; i < NCH; i++) chk("count", count[i*CNT_W +: CNT_W], m_cnt[i]);
`endif
      if (evt_valid && !pv) chk("offer_lowest", evt_ch, lowest(m_pend_before));
      if (pv && !phs && !pclr) begin
        chk("offer_hold", evt_valid, 1);
        chk("offer_ch_hold", evt_ch, pch);
      end
      if (evt_valid && evt_ready) chk("accept_pending", m_pend[evt_ch], 1);
    end
    hs    = rst_n && evt_valid && evt_ready;
    hs_ch = evt_ch;
    pv    = rst_n && evt_valid;
    phs   = hs;
    pch   = evt_ch;
    pclr  = clr;
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rst_n = 0; sense = '1; clr = 0; evt_ready = 0;
    #1;
    chk("rst_run", run, 0);
    chk("rst_brk", brk, 0);
    chk("rst_toggle", toggle, 0);
    chk("rst_valid", evt_valid, 0);
    chk("rst_ch", evt_ch, 0);
    step(3);
    rst_n = 1;
    chk("run_before_edge", run, 0);
    step(1);
    chk("run_after_edge", run, 1);
  endtask

  typedef struct {
    logic [NCH-1:0] mask;
    int             low;
    logic [NCH-1:0] exp_brk;
    logic [NCH-1:0] exp_tog;
    logic [15:0]    exp_cnt;
  } vec_t;

  vec_t vecs[6];
  int   n_hs;
  int   offers[$];
  bit   got;

  initial begin
    vecs[0] = '{4'b0001, 8,  4'b0000, 4'b0000, 16'h0000};
    vecs[1] = '{4'b1000, 20, 4'b1000, 4'b1000, 16'h1000};
    vecs[2] = '{4'b0100, 24, 4'b0100, 4'b1100, 16'h1100};
    vecs[3] = '{4'b1000, 20, 4'b1000, 4'b0100, 16'h2100};
    vecs[4] = '{4'b0011, 4,  4'b0000, 4'b0100, 16'h2100};
    vecs[5] = '{4'b0110, 12, 4'b0110, 4'b0010, 16'h2210};

    // Table-driven pulse widths
    do_reset();
    evt_ready = 1;
    for (int v = 0; v < 6; v++) begin
      sense = ~vecs[v].mask;
      step(vecs[v].low);
      sense = '1;
      step(3);
      chk("tbl_brk", brk, vecs[v].exp_brk);
      step(20);
      chk("tbl_toggle", toggle, vecs[v].exp_tog);
`ifdef BEAM_MONITOR_COUNT_EN
      chk("tbl_count", count, vecs[v].exp_cnt);
`endif
      chk("tbl_drained", evt_valid, 0);
    end

    // Single break on ch1 and offer latency
    do_reset();
    evt_ready = 1;
    sense[1] = 0;
    got = 0;
    for (int k = 0; k < 30 && !got; k++) begin step(1); if (brk[1]) got = 1; end
    chk("ch1_brk_rise", got, 1);
    chk("ch1_valid_t0", evt_valid, 0);
    step(1);
    chk("ch1_valid_t1", evt_valid, 0);
    step(1);
    chk("ch1_valid_t2", evt_valid, 1);
    chk("ch1_evt_ch", evt_ch, 1);
    step(10);
    chk("ch1_toggle", toggle, 4'b0010);
`ifdef BEAM_MONITOR_COUNT_EN
    chk("ch1_count", count[1*CNT_W +: CNT_W], 1);
`endif
    sense = '1;
    step(20);

    // Simultaneous break on ch2 and ch0: lowest first, each once
    do_reset();
    evt_ready = 1;
    sense = 4'b1010;
    offers.delete();
    for (int k = 0; k < 40; k++) begin
      if (evt_valid && evt_ready) offers.push_back(int'(evt_ch));
      step(1);
    end
    chk("dual_offers", offers.size(), 2);
    if (offers.size() == 2) begin
      chk("dual_first", offers[0], 0);
      chk("dual_second", offers[1], 2);
    end
    sense = '1;
    step(20);

    // Coalescing: ch3 breaks three times while the consumer stalls
    do_reset();
    evt_ready = 0;
    repeat (3) begin sense[3] = 0; step(20); sense[3] = 1; step(20); end
    chk("coal_toggle", toggle[3], 1);
`ifdef BEAM_MONITOR_COUNT_EN
    chk("coal_count", count[3*CNT_W +: CNT_W], 3);
`endif
    chk("coal_valid", evt_valid, 1);
    chk("coal_ch", evt_ch, 3);
    evt_ready = 1;
    n_hs = 0;
    for (int k = 0; k < 10; k++) begin
      if (evt_valid && evt_ready) n_hs++;
      step(1);
    end
    chk("coal_offers", n_hs, 1);

    // Saturation after 17 breaks on ch1, then clr
    do_reset();
    evt_ready = 1;
    repeat (16) begin sense[1] = 0; step(20); sense[1] = 1; step(20); end
    evt_ready = 0;
    sense[1] = 0;
    step(20);
`ifdef BEAM_MONITOR_COUNT_EN
    chk("sat_count", count[1*CNT_W +: CNT_W], 15);
`endif
    chk("sat_toggle", toggle[1], 1);
    chk("sat_valid", evt_valid, 1);
    clr = 1;
    step(1);
    clr = 0;
    chk("clr_toggle", toggle, 0);
    chk("clr_valid", evt_valid, 0);
    chk("clr_brk", brk[1], 1);
`ifdef BEAM_MONITOR_COUNT_EN
    chk("clr_count", count, 0);
`endif
    step(3);
    chk("clr_no_offer", evt_valid, 0);

    // Reset in the middle of an offer
    do_reset();
    evt_ready = 0;
    sense[2] = 0;
    got = 0;
    for (int k = 0; k < 40 && !got; k++) begin step(1); if (evt_valid) got = 1; end
    chk("mid_offer_up", got, 1);
    rst_n = 0;
    #1;
    chk("mid_rst_run", run, 0);
    chk("mid_rst_brk", brk, 0);
    chk("mid_rst_toggle", toggle, 0);
    chk("mid_rst_valid", evt_valid, 0);
    chk("mid_rst_ch", evt_ch, 0);
`ifdef BEAM_MONITOR_COUNT_EN
    chk("mid_rst_count", count, 0);
`endif
    sense = '1;
    step(2);
    rst_n = 1;
    chk("mid_run_low", run, 0);
    step(1);
    chk("mid_run_high", run, 1);
    chk("mid_no_offer", evt_valid, 0);

    // Randomized traffic against the reference model
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < NCH; i++) if ($urandom_range(0, 14) == 0) sense[i] = ~sense[i];
      evt_ready = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 199) == 0);
      step(1);
    end
    clr = 0;
    evt_ready = 1;
    got = 0;
    for (int k = 0; k < 100 && !got; k++) begin
      step(1);
      if (!evt_valid && m_pend == 0 && m_evt == 0) got = 1;
    end
    chk("rand_drain", got, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
